// File: rtl/tv80_bus_bridge.sv
// TV80 CPU bus to NCH peripheral channels: address decode, optional wait states, one-clock strobes.
// Strobe lands ws+1 clocks after the access is seen; waits are asserted only for the decoded channel's count.
module tv80_bus_bridge #(
    parameter int                 NCH       = 4,
    parameter int                 AW        = 16,
    parameter logic [NCH*AW-1:0]  CH_BASE   = '0,
    parameter logic [NCH*AW-1:0]  CH_MASK   = '0,
    parameter logic [NCH-1:0]     CH_IO     = '0,
    parameter logic [NCH*4-1:0]   CH_WS     = '0,
    parameter logic [7:0]         IDLE_BYTE = 8'hFF,
    parameter logic [7:0]         INTA_BYTE = 8'hFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AW-1:0]     cpu_a,
    input  logic [7:0]        cpu_dout,
    input  logic              cpu_mreq_n,
    input  logic              cpu_iorq_n,
    input  logic              cpu_rd_n,
    input  logic              cpu_wr_n,
    input  logic              cpu_m1_n,
    output logic [7:0]        cpu_di,
    output logic              cpu_wait_n,
    output logic [NCH-1:0]    ch_sel,
    output logic              ch_rd_stb,
    output logic              ch_wr_stb,
    output logic [AW-1:0]     ch_addr,
    output logic [7:0]        ch_wdata,
    input  logic [NCH*8-1:0]  ch_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NCH-1:0]  sel_q, sel_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            wr_dir_q, wr_dir_d;
    logic            rd_hit_q, rd_hit_d;

    logic            rd, wr, mreq, iorq, m1;
    logic            mem_acc, io_acc, inta, xfer_acc, bus_act;
    logic [NCH-1:0]  hit_vec, hit_oh;
    logic [3:0]      hit_ws;
    logic            hit_any;
    logic [7:0]      rd_mux;

    always_comb begin
        rd       = ~cpu_rd_n;
        wr       = ~cpu_wr_n;
        mreq     = ~cpu_mreq_n;
        iorq     = ~cpu_iorq_n;
        m1       = ~cpu_m1_n;
        mem_acc  = mreq & ~iorq & (rd ^ wr);
        io_acc   = iorq & ~mreq & ~m1 & (rd ^ wr);
        inta     = iorq & m1;
        xfer_acc = mem_acc | io_acc;
        bus_act  = xfer_acc | inta;
    end

    // Iterate high-to-low so the lowest matching index is the one left standing.
    always_comb begin
        hit_vec = '0;
        hit_oh  = '0;
        hit_ws  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            hit_vec[i] = (CH_IO[i] ? io_acc : mem_acc) &&
                         ((cpu_a & CH_MASK[i*AW +: AW]) == (CH_BASE[i*AW +: AW] & CH_MASK[i*AW +: AW]));
            if (hit_vec[i]) begin
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
                hit_ws    = CH_WS[i*4 +: 4];
            end
        end
        hit_any = |hit_vec;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_dir_d = wr_dir_q;
        rd_hit_d = rd_hit_q;
        case (state_q)
            ST_IDLE: begin
                if (hit_any) begin
                    sel_d    = hit_oh;
                    addr_d   = cpu_a;
                    wdata_d  = cpu_dout;
                    wr_dir_d = wr;
                    rd_hit_d = ~wr;
                    if (hit_ws != 4'd0) begin
                        state_d = ST_WAIT;
                        cnt_d   = hit_ws - 4'd1;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end else if (bus_act) begin
                    state_d  = ST_HOLD;
                    rd_hit_d = 1'b0;
                end
            end
            ST_WAIT: begin
                // CPU gave up the cycle: drop it silently, no strobe.
                if (!xfer_acc) begin
                    state_d  = ST_IDLE;
                    sel_d    = '0;
                    rd_hit_d = 1'b0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACTIVE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!bus_act) begin
                    state_d  = ST_IDLE;
                    sel_d    = '0;
                    rd_hit_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_dir_q <= 1'b0;
            rd_hit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_dir_q <= wr_dir_d;
            rd_hit_q <= rd_hit_d;
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel_q[i]) begin
                rd_mux = rd_mux | ch_rdata[i*8 +: 8];
            end
        end
    end

    always_comb begin
        cpu_wait_n = (state_q != ST_WAIT);
        ch_rd_stb  = (state_q == ST_ACTIVE) & ~wr_dir_q;
        ch_wr_stb  = (state_q == ST_ACTIVE) &  wr_dir_q;
        ch_sel     = sel_q;
        ch_addr    = addr_q;
        ch_wdata   = wdata_q;
        if (inta) begin
            cpu_di = INTA_BYTE;
        end else if (rd_hit_q && (state_q == ST_ACTIVE || state_q == ST_HOLD)) begin
            cpu_di = rd_mux;
        end else begin
            cpu_di = IDLE_BYTE;
        end
    end

endmodule

// File: tb/tb_tv80_bus_bridge.sv
// Randomized bench for tv80_bus_bridge: a CPU-like driver queues expected channel strobes,
// a strobe monitor pops and checks them; per-access wait counts and read data are checked inline.
module tb_tv80_bus_bridge;

    localparam int NCH = 4;
    localparam int AW  = 16;

    // Channel map: 0 mem 4000/C000 ws0, 1 mem 8800/F800 ws2, 2 io 00FE/00FF ws3, 3 mem 8000/F000 ws1
    localparam logic [NCH*AW-1:0] P_BASE = {16'h8000, 16'h00FE, 16'h8800, 16'h4000};
    localparam logic [NCH*AW-1:0] P_MASK = {16'hF000, 16'h00FF, 16'hF800, 16'hC000};
    localparam logic [NCH-1:0]    P_IO   = 4'b0100;
    localparam logic [NCH*4-1:0]  P_WS   = {4'd1, 4'd3, 4'd2, 4'd0};

    int m_base [4] = '{32'h4000, 32'h8800, 32'h00FE, 32'h8000};
    int m_mask [4] = '{32'hC000, 32'hF800, 32'h00FF, 32'hF000};
    int m_io   [4] = '{0, 0, 1, 0};
    int m_ws   [4] = '{0, 2, 3, 1};

    logic              clk = 1'b0;
    logic              reset_n;
    logic [AW-1:0]     cpu_a;
    logic [7:0]        cpu_dout;
    logic              cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n;
    logic [7:0]        cpu_di;
    logic              cpu_wait_n;
    logic [NCH-1:0]    ch_sel;
    logic              ch_rd_stb, ch_wr_stb;
    logic [AW-1:0]     ch_addr;
    logic [7:0]        ch_wdata;
    logic [NCH*8-1:0]  ch_rdata;

    tv80_bus_bridge #(
        .NCH(NCH), .AW(AW), .CH_BASE(P_BASE), .CH_MASK(P_MASK), .CH_IO(P_IO),
        .CH_WS(P_WS), .IDLE_BYTE(8'hFF), .INTA_BYTE(8'hE7)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_dout(cpu_dout),
        .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n),
        .cpu_wr_n(cpu_wr_n), .cpu_m1_n(cpu_m1_n), .cpu_di(cpu_di),
        .cpu_wait_n(cpu_wait_n), .ch_sel(ch_sel), .ch_rd_stb(ch_rd_stb),
        .ch_wr_stb(ch_wr_stb), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_rdata(ch_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic [3:0]  sel;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference decode: first channel whose space and masked address match, else -1.
    function automatic int model_chan(input bit is_io, input logic [15:0] a);
        for (int i = 0; i < 4; i++) begin
            if (m_io[i] == int'(is_io) && ((int'(a) & m_mask[i]) == (m_base[i] & m_mask[i])))
                return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (ch_rd_stb || ch_wr_stb) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got rd=%b wr=%b addr=%h want none", ch_rd_stb, ch_wr_stb, ch_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("stb_dir",   {30'd0, ch_wr_stb, ch_rd_stb}, e.wr ? 32'd2 : 32'd1);
                chk("stb_addr",  {16'd0, ch_addr}, {16'd0, e.a});
                chk("stb_wdata", {24'd0, ch_wdata}, e.wr ? {24'd0, e.d} : {24'd0, ch_wdata});
                chk("stb_sel",   {28'd0, ch_sel}, {28'd0, e.sel});
                chk("stb_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic bus_idle();
        cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_m1_n = 1'b1;
    endtask

    task automatic drive(input int kind, input bit wr, input logic [15:0] a, input logic [7:0] d);
        cpu_a      = a;
        cpu_dout   = d;
        cpu_mreq_n = !(kind == 0);
        cpu_iorq_n = !(kind != 0);
        cpu_m1_n   = !(kind == 2);
        cpu_rd_n   = !(kind != 2 && !wr);
        cpu_wr_n   = !(kind != 2 && wr);
    endtask

    // kind: 0 memory, 1 I/O, 2 interrupt acknowledge
    task automatic run_access(input int kind, input bit wr, input logic [15:0] a, input logic [7:0] d);
        int ch, ws, waits;
        logic [3:0] exp_sel;
        logic [7:0] exp_di;
        exp_t e;
        ch      = (kind == 2) ? -1 : model_chan(kind == 1, a);
        ws      = (ch >= 0) ? m_ws[ch] : 0;
        exp_sel = (ch >= 0) ? 4'(1 << ch) : 4'd0;
        if (kind == 2)            exp_di = 8'hE7;
        else if (ch >= 0 && !wr)  exp_di = ch_rdata[ch*8 +: 8];
        else                      exp_di = 8'hFF;
        @(posedge clk); #1;
        reset_n = 1'b1;
        drive(kind, wr, a, d);
        if (ch >= 0) begin
            e.wr = wr; e.a = a; e.d = d; e.sel = exp_sel; e.cyc = cyc + 1 + ws;
            exp_q.push_back(e);
        end
        waits = 0;
        @(posedge clk);
        for (int k = 0; k < ws + 2; k++) begin
            @(negedge clk);
            if (!cpu_wait_n) waits++;
            if (k == 0) chk("sel_after_detect", {28'd0, ch_sel}, {28'd0, exp_sel});
            if (k == 0 && ws > 0) chk("di_in_wait", {24'd0, cpu_di}, 32'hFF);
        end
        chk("wait_clocks", waits, ws);
        chk("cpu_di_hold", {24'd0, cpu_di}, {24'd0, exp_di});
        @(posedge clk); #1;
        bus_idle();
        @(posedge clk);
        @(negedge clk);
        chk("sel_idle", {28'd0, ch_sel}, 32'd0);
        chk("di_idle", {24'd0, cpu_di}, 32'hFF);
        chk("wait_n_idle", {31'd0, cpu_wait_n}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        int kind, pick;
        reset_n  = 1'b0;
        cpu_a    = '0;
        cpu_dout = '0;
        ch_rdata = $urandom;
        bus_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wait_n", {31'd0, cpu_wait_n}, 32'd1);
        chk("rst_sel",    {28'd0, ch_sel}, 32'd0);
        chk("rst_stb",    {30'd0, ch_rd_stb, ch_wr_stb}, 32'd0);
        chk("rst_addr",   {16'd0, ch_addr}, 32'd0);
        chk("rst_wdata",  {24'd0, ch_wdata}, 32'd0);
        chk("rst_di",     {24'd0, cpu_di}, 32'hFF);

        // First access presented on the same clock reset releases.
        run_access(0, 1'b1, 16'h5A5A, 8'h3C);
        ch_rdata = {8'h11, 8'h5B, 8'h22, 8'h33};
        run_access(1, 1'b0, 16'h12FE, 8'h00);
        run_access(0, 1'b0, 16'h2000, 8'h00);
        run_access(2, 1'b0, 16'h0038, 8'h00);
        run_access(0, 1'b0, 16'h8123, 8'h00);
        run_access(0, 1'b1, 16'h8955, 8'hA5);
        run_access(0, 1'b0, 16'h00FE, 8'h00);
        run_access(1, 1'b1, 16'h40FE, 8'h77);
        run_access(1, 1'b0, 16'h00FD, 8'h00);

        // Refresh, mreq+iorq together, rd+wr together: none are accesses.
        @(posedge clk); #1;
        cpu_a = 16'h4001; cpu_mreq_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("refresh_sel", {28'd0, ch_sel}, 32'd0);
        chk("refresh_wait", {31'd0, cpu_wait_n}, 32'd1);
        #1; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mreq_iorq_sel", {28'd0, ch_sel}, 32'd0);
        #1; cpu_iorq_n = 1'b1; cpu_wr_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rd_wr_sel", {28'd0, ch_sel}, 32'd0);
        chk("rd_wr_di", {24'd0, cpu_di}, 32'hFF);
        #1; bus_idle();
        run_access(0, 1'b1, 16'h4ABC, 8'h5E);

        // Abort: strobes drop during the first wait clock.
        @(posedge clk); #1;
        drive(0, 1'b1, 16'h8A00, 8'h99);
        @(posedge clk);
        @(negedge clk);
        chk("abort_in_wait", {31'd0, cpu_wait_n}, 32'd0);
        #1; bus_idle();
        @(posedge clk);
        @(negedge clk);
        chk("abort_sel", {28'd0, ch_sel}, 32'd0);
        chk("abort_wait_n", {31'd0, cpu_wait_n}, 32'd1);
        repeat (4) @(posedge clk);

        // Reset asserted for one clock on the 2nd wait clock of a ws=3 read.
        @(posedge clk); #1;
        drive(1, 1'b0, 16'h33FE, 8'h00);
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_reset_wait", {31'd0, cpu_wait_n}, 32'd0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus_idle();
        @(negedge clk);
        chk("midrst_wait_n", {31'd0, cpu_wait_n}, 32'd1);
        chk("midrst_sel", {28'd0, ch_sel}, 32'd0);
        chk("midrst_addr", {16'd0, ch_addr}, 32'd0);
        chk("midrst_di", {24'd0, cpu_di}, 32'hFF);
        repeat (6) @(posedge clk);

        for (int n = 0; n < 60; n++) begin
            ch_rdata = $urandom;
            kind = $urandom_range(0, 9);
            pick = $urandom_range(0, 3);
            a = 16'($urandom);
            if (kind <= 5) begin
                case (pick)
                    0: a = 16'h4000 | (a & 16'h3FFF);
                    1: a = 16'h8800 | (a & 16'h07FF);
                    2: a = 16'h8000 | (a & 16'h07FF);
                    default: ;
                endcase
                run_access(0, 1'($urandom), a, 8'($urandom));
            end else if (kind <= 8) begin
                if (pick < 2) a[7:0] = 8'hFE;
                run_access(1, 1'($urandom), a, 8'($urandom));
            end else begin
                run_access(2, 1'b0, a, 8'($urandom));
            end
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tv80_bus_bridge.md
TV80_BUS_BRIDGE -- requirements
Module: tv80_bus_bridge

Interface
REQ-001 Parameter NCH, default 4: number of peripheral channels, range 1..8.
REQ-002 Parameter AW, default 16: CPU address width.
REQ-003 Parameter CH_BASE, default 0 (NCH*AW bits): per-channel base address, channel i in bits [i*AW +: AW].
REQ-004 Parameter CH_MASK, default 0 (NCH*AW bits): per-channel compare mask; 1 = bit compared.
REQ-005 Parameter CH_IO, default 0 (NCH bits): per-channel space, 1 = I/O, 0 = memory.
REQ-006 Parameter CH_WS, default 0 (NCH*4 bits): per-channel wait-state count, 0..15.
REQ-007 Parameter IDLE_BYTE, default 8'hFF: read data for unmapped or inactive reads.
REQ-008 Parameter INTA_BYTE, default 8'hFF: data driven during interrupt acknowledge.
REQ-009 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-010 Port reset_n, input, 1: synchronous, active-low reset.
REQ-011 Port cpu_a, input, AW: CPU address.
REQ-012 Port cpu_dout, input, 8: CPU write data.
REQ-013 Port cpu_mreq_n / cpu_iorq_n / cpu_rd_n / cpu_wr_n / cpu_m1_n, input, 1 each: CPU bus strobes, active-low.
REQ-014 Port cpu_di, output, 8: read data to CPU.
REQ-015 Port cpu_wait_n, output, 1: wait request to CPU, active-low.
REQ-016 Port ch_sel, output, NCH: one-hot selected channel, held for the whole access.
REQ-017 Port ch_rd_stb / ch_wr_stb, output, 1 each: single-clock read / write pulse.
REQ-018 Port ch_addr, output, AW: address captured at access start.
REQ-019 Port ch_wdata, output, 8: write data captured at access start.
REQ-020 Port ch_rdata, input, NCH*8: per-channel read data, channel i in bits [i*8 +: 8].

Function
REQ-021 Access types:
- MEM = !mreq_n & iorq_n & (!rd_n ^ !wr_n).
- IO = !iorq_n & mreq_n & m1_n & (!rd_n ^ !wr_n).
- INTA = !iorq_n & !m1_n.
- Refresh (mreq low, rd/wr high), simultaneous mreq+iorq, and rd+wr both low are NOT accesses.
REQ-022 Hit rule: channel i hits when the space matches CH_IO[i] and (cpu_a & mask_i) == (base_i & mask_i); the lowest index wins.
REQ-023 FSM states are IDLE, WAIT, ACTIVE, HOLD.
REQ-024 IDLE transitions:
- On MEM/IO with a hit: capture channel index, cpu_a, cpu_dout and direction, and assert ch_sel.
- If CH_WS > 0: go to WAIT and load the counter with CH_WS-1; otherwise go to ACTIVE.
- On a miss or INTA: go to HOLD.
REQ-025 WAIT: cpu_wait_n = 0; decrement each clock; at counter 0, go to ACTIVE. cpu_wait_n is low for exactly CH_WS clocks, starting the clock after detection.
REQ-026 ACTIVE lasts exactly one clock and pulses ch_rd_stb or ch_wr_stb per the captured direction, then goes to HOLD.
REQ-027 HOLD: wait until the access condition is false, then go to IDLE. A new access is never recognised without an intervening idle-bus clock.
REQ-028 cpu_di:
- ch_rdata of the captured channel in ACTIVE/HOLD of a hit read.
- INTA_BYTE while INTA is true.
- IDLE_BYTE otherwise, including during WAIT.
REQ-029 Abort: if the access condition drops in WAIT, go to IDLE with no strobe; ch_sel clears.
REQ-030 ch_sel clears on entry to IDLE. ch_addr/ch_wdata hold their values until the next capture.
REQ-031 cpu_wait_n is 1 in every state except WAIT; a miss or INTA never inserts waits.

Reset
REQ-032 On reset_n = 0 at a clock edge, regardless of state (including mid-WAIT), the block SHALL enter IDLE with:
- cpu_wait_n = 1, ch_sel = 0, ch_rd_stb = ch_wr_stb = 0;
- ch_addr = 0, ch_wdata = 0, counter = 0;
- cpu_di = IDLE_BYTE.
REQ-033 The first access after reset release SHALL be recognised on the first clock its condition is true.

Verification
REQ-034 Memory write, channel 0 (base 16'h4000, mask 16'hC000, WS 0), A = 16'h5A5A, D = 8'h3C -> ch_sel = 4'b0001 from the next clock; ch_wr_stb high 1 clock, one clock after detection; ch_addr = 16'h5A5A; ch_wdata = 8'h3C; cpu_wait_n stays 1.
REQ-035 I/O read, channel 2 (IO, base 16'h00FE, mask 16'h00FF, WS 3), ch_rdata[2] = 8'h5B -> cpu_wait_n low for exactly 3 clocks; ch_rd_stb pulses on the next clock; cpu_di = 8'h5B until rd_n rises.
REQ-036 Read at an unmapped address -> no strobe; ch_sel = 0; cpu_di = 8'hFF; cpu_wait_n = 1.
REQ-037 INTA cycle (iorq_n = 0, m1_n = 0) with INTA_BYTE = 8'hE7 -> cpu_di = 8'hE7; no strobe; refresh cycle -> no state change.
REQ-038 reset_n = 0 for 1 clock during the 2nd WAIT clock of a WS = 3 access -> next clock IDLE with cpu_wait_n = 1, ch_sel = 0, and no strobe ever emitted.
